// File: rtl/trap_controller.sv
// trap_controller
// Machine-mode trap sequencer sitting between the pipeline and the CSR file.
// It picks one event per boundary (interrupt > exception > mret), pulses the
// CSR update strobe together with a pipeline flush, then hands the new fetch
// PC to the fetch unit over a valid/ready handshake.
module trap_controller #(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    // Pipeline-side event sources
    input  logic        pipe_ready,
    input  logic        ex_valid,
    input  logic [3:0]  ex_cause,
    input  logic [31:0] ex_pc,
    input  logic        mret_valid,
    input  logic [31:0] int_pc,

    // Live CSR values
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mie,
    input  logic [31:0] csr_mip,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,

    // CSR update strobes and trap data
    output logic        exception_occurred,
    output logic        exception_returned,
    output logic [31:0] new_mepc,
    output logic [31:0] new_mcause,
    output logic [31:0] new_mtval,

    // Pipeline control
    output logic        flush,
    output logic        busy,

    // Fetch redirect handshake
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_INT  = 2'd1,
        EV_EXC  = 2'd2,
        EV_MRET = 2'd3
    } event_t;

    // Machine external (11), timer (7) and software (3) interrupt bits.
    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

    localparam logic [3:0] CODE_MEI = 4'd11;
    localparam logic [3:0] CODE_MSI = 4'd3;
    localparam logic [3:0] CODE_MTI = 4'd7;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_exception_occurred;
    logic        r_exception_returned;
    logic        r_flush;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_new_mepc;
    logic [31:0] r_new_mcause;

    // ------------------------------------------------------------------
    // Combinational event decode
    // ------------------------------------------------------------------
    logic [31:0] w_pending;
    logic        w_irq;
    logic [3:0]  w_irq_code;
    event_t      w_event;
    logic        w_vectored;
    logic [31:0] w_trap_base;
    logic [31:0] w_target;
    logic [31:0] w_cap_mepc;
    logic [31:0] w_cap_mcause;

    assign w_pending = csr_mie & csr_mip & IRQ_MASK;
    assign w_irq     = csr_mstatus[3] && (w_pending != 32'd0);

    // Interrupt sub-priority: external beats software beats timer.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        w_irq_code = CODE_MTI;
        if (w_pending[11]) begin
            w_irq_code = CODE_MEI;
        end else if (w_pending[3]) begin
            w_irq_code = CODE_MSI;
        end
    end

    // Choose the single event to capture this boundary, if any.
    always_comb begin
        w_event = EV_NONE;
        if (pipe_ready) begin
            if (w_irq) begin
                w_event = EV_INT;
            end else if (ex_valid) begin
                w_event = EV_EXC;
            end else if (mret_valid) begin
                w_event = EV_MRET;
            end
        end
    end

    // Vector table is only used for interrupts in mtvec mode 01; modes 10/11
    // fall back to the direct base address.
    assign w_vectored  = VECTORED_EN && (csr_mtvec[1:0] == 2'b01);
    assign w_trap_base = {csr_mtvec[31:2], 2'b00};

    // Redirect target and trap data for whichever event is being captured.
    always_comb begin
        w_target     = w_trap_base;
        w_cap_mepc   = r_new_mepc;
        w_cap_mcause = r_new_mcause;
        unique case (w_event)
            EV_INT: begin
                w_cap_mepc   = int_pc;
                w_cap_mcause = {1'b1, 27'd0, w_irq_code};
                if (w_vectored) begin
                    w_target = w_trap_base + {26'd0, w_irq_code, 2'b00};
                end
            end
            EV_EXC: begin
                w_cap_mepc   = ex_pc;
                w_cap_mcause = {28'd0, ex_cause};
            end
            EV_MRET: begin
                // mret target uses mepc as sampled now, before the CSR file
                // updates anything at the end of COMMIT.
                w_target = {csr_mepc[31:2], 2'b00};
            end
            default: begin
                w_target = w_trap_base;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state and output registers are reset here; there is no memory, so nothing is left to power-up value.
        if (!rst_n) begin
            r_state              <= S_IDLE;
            r_exception_occurred <= 1'b0;
            r_exception_returned <= 1'b0;
            r_flush              <= 1'b0;
            r_redirect_valid     <= 1'b0;
            r_redirect_pc        <= 32'd0;
            r_new_mepc           <= 32'd0;
            r_new_mcause         <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            unique case (r_state)
                S_IDLE: begin
                    r_exception_occurred <= 1'b0;
                    r_exception_returned <= 1'b0;
                    r_flush              <= 1'b0;
                    r_redirect_valid     <= 1'b0;
                    if (w_event != EV_NONE) begin
                        r_state              <= S_COMMIT;
                        r_flush              <= 1'b1;
                        r_exception_occurred <= (w_event != EV_MRET);
                        r_exception_returned <= (w_event == EV_MRET);
                        r_redirect_pc        <= w_target;
                        r_new_mepc           <= w_cap_mepc;
                        r_new_mcause         <= w_cap_mcause;
                    end
                end

                S_COMMIT: begin
                    r_exception_occurred <= 1'b0;
                    r_exception_returned <= 1'b0;
                    r_flush              <= 1'b0;
                    r_redirect_valid     <= 1'b1;
                    r_state              <= S_REDIRECT;
                end

                S_REDIRECT: begin
                    if (redirect_ready) begin
                        r_redirect_valid <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end

                default: begin
                    r_exception_occurred <= 1'b0;
                    r_exception_returned <= 1'b0;
                    r_flush              <= 1'b0;
                    r_redirect_valid     <= 1'b0;
                    r_state              <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign exception_occurred = r_exception_occurred;
    assign exception_returned = r_exception_returned;
    assign flush              = r_flush;
    assign redirect_valid     = r_redirect_valid;
    assign redirect_pc        = r_redirect_pc;
    assign new_mepc           = r_new_mepc;
    assign new_mcause         = r_new_mcause;
    assign new_mtval          = 32'd0;
    assign busy               = (r_state != S_IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller
// Directed scenarios followed by randomized events, each checked against a
// behavioural model of the trap rules (priority, cause encoding, vector
// target) and of the COMMIT / REDIRECT cycle timeline.
module tb_trap_controller;

    localparam bit VEC_EN = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_ready;
    logic        ex_valid;
    logic [3:0]  ex_cause;
    logic [31:0] ex_pc;
    logic        mret_valid;
    logic [31:0] int_pc;
    logic [31:0] csr_mstatus;
    logic [31:0] csr_mie;
    logic [31:0] csr_mip;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        exception_occurred;
    logic        exception_returned;
    logic [31:0] new_mepc;
    logic [31:0] new_mcause;
    logic [31:0] new_mtval;
    logic        flush;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    always #5 clk = ~clk;

    trap_controller #(.VECTORED_EN(VEC_EN)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pipe_ready         (pipe_ready),
        .ex_valid           (ex_valid),
        .ex_cause           (ex_cause),
        .ex_pc              (ex_pc),
        .mret_valid         (mret_valid),
        .int_pc             (int_pc),
        .csr_mstatus        (csr_mstatus),
        .csr_mie            (csr_mie),
        .csr_mip            (csr_mip),
        .csr_mtvec          (csr_mtvec),
        .csr_mepc           (csr_mepc),
        .exception_occurred (exception_occurred),
        .exception_returned (exception_returned),
        .new_mepc           (new_mepc),
        .new_mcause         (new_mcause),
        .new_mtval          (new_mtval),
        .flush              (flush),
        .busy               (busy),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .redirect_ready     (redirect_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: trap data last written to the CSR file.
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;

    // kind: 0 = nothing captured, 1 = trap, 2 = mret
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] target;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // What the controller should do at the next edge given the current inputs.
    function automatic exp_t predict();
        exp_t e;
        int   prio [3];
        int   code;
        bit   found;
        prio  = '{11, 3, 7};
        found = 1'b0;
        code  = 0;
        e.kind   = 2'd0;
        e.mepc   = m_mepc;
        e.mcause = m_mcause;
        e.target = 32'd0;
        if (!pipe_ready) return e;
        if (csr_mstatus[3]) begin
            for (int i = 0; i < 3; i++) begin
                if (!found && csr_mie[prio[i]] && csr_mip[prio[i]]) begin
                    found = 1'b1;
                    code  = prio[i];
                end
            end
        end
        if (found) begin
            e.kind   = 2'd1;
            e.mepc   = int_pc;
            e.mcause = 32'h8000_0000 + 32'(code);
            e.target = csr_mtvec & 32'hFFFF_FFFC;
            if (VEC_EN && csr_mtvec[1:0] == 2'b01) e.target = e.target + 32'(code * 4);
        end else if (ex_valid) begin
            e.kind   = 2'd1;
            e.mepc   = ex_pc;
            e.mcause = 32'(ex_cause);
            e.target = csr_mtvec & 32'hFFFF_FFFC;
        end else if (mret_valid) begin
            e.kind   = 2'd2;
            e.target = csr_mepc & 32'hFFFF_FFFC;
        end
        return e;
    endfunction

    task automatic quiet();
        pipe_ready     = 1'b1;
        ex_valid       = 1'b0;
        mret_valid     = 1'b0;
        csr_mip        = 32'd0;
        redirect_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, " exc_occ"}, exception_occurred, 1'b0);
        check_bit({tag, " exc_ret"}, exception_returned, 1'b0);
        check_bit({tag, " flush"}, flush, 1'b0);
        check_bit({tag, " busy"}, busy, 1'b0);
        check_bit({tag, " rvalid"}, redirect_valid, 1'b0);
        check({tag, " rpc"}, redirect_pc, 32'd0);
        check({tag, " mepc"}, new_mepc, 32'd0);
        check({tag, " mcause"}, new_mcause, 32'd0);
        check({tag, " mtval"}, new_mtval, 32'd0);
    endtask

    // Drive one full capture -> COMMIT -> REDIRECT -> IDLE sequence from the
    // inputs already applied; redirect_ready stays low for ready_delay cycles.
    task automatic run_event(input string tag, input int ready_delay);
        exp_t e;
        e = predict();
        check_bit({tag, " idle_before"}, busy, 1'b0);
        tick();  // capture edge
        if (e.kind != 2'd0) begin
            m_mepc   = e.mepc;
            m_mcause = e.mcause;
        end
        // Everything below should be ignored while the sequence is running.
        pipe_ready     = 1'b1;
        ex_valid       = 1'b1;
        ex_cause       = 4'($urandom);
        ex_pc          = $urandom;
        mret_valid     = 1'($urandom);
        csr_mip        = 32'hFFFF_FFFF;
        csr_mie        = 32'hFFFF_FFFF;
        csr_mstatus    = 32'hFFFF_FFFF;
        int_pc         = $urandom;
        redirect_ready = (ready_delay == 0);
        // Cycle 1: COMMIT
        check_bit({tag, " c1 busy"}, busy, 1'b1);
        check_bit({tag, " c1 flush"}, flush, 1'b1);
        check_bit({tag, " c1 exc_occ"}, exception_occurred, e.kind == 2'd1);
        check_bit({tag, " c1 exc_ret"}, exception_returned, e.kind == 2'd2);
        check_bit({tag, " c1 rvalid"}, redirect_valid, 1'b0);
        check({tag, " c1 mepc"}, new_mepc, m_mepc);
        check({tag, " c1 mcause"}, new_mcause, m_mcause);
        check({tag, " c1 mtval"}, new_mtval, 32'd0);
        tick();
        // Cycle 2: REDIRECT
        check_bit({tag, " c2 rvalid"}, redirect_valid, 1'b1);
        check({tag, " c2 rpc"}, redirect_pc, e.target);
        check_bit({tag, " c2 flush"}, flush, 1'b0);
        check_bit({tag, " c2 exc_occ"}, exception_occurred, 1'b0);
        check_bit({tag, " c2 exc_ret"}, exception_returned, 1'b0);
        check_bit({tag, " c2 busy"}, busy, 1'b1);
        for (int i = 0; i < ready_delay; i++) begin
            tick();
            check_bit({tag, " hold rvalid"}, redirect_valid, 1'b1);
            check({tag, " hold rpc"}, redirect_pc, e.target);
            check_bit({tag, " hold busy"}, busy, 1'b1);
            check_bit({tag, " hold strobe"}, exception_occurred | exception_returned | flush, 1'b0);
            check({tag, " hold mcause"}, new_mcause, m_mcause);
        end
        redirect_ready = 1'b1;
        tick();  // handshake edge
        quiet();
        check_bit({tag, " end busy"}, busy, 1'b0);
        check_bit({tag, " end rvalid"}, redirect_valid, 1'b0);
        check({tag, " end mepc"}, new_mepc, m_mepc);
        check({tag, " end mcause"}, new_mcause, m_mcause);
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        // ---------------- Reset ----------------
        rst_n       = 1'b0;
        ex_cause    = 4'd0;
        ex_pc       = 32'd0;
        int_pc      = 32'd0;
        csr_mstatus = 32'd0;
        csr_mie     = 32'd0;
        csr_mtvec   = 32'd0;
        csr_mepc    = 32'd0;
        quiet();
        m_mepc   = 32'd0;
        m_mcause = 32'd0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check_bit("post_reset busy", busy, 1'b0);

        // ---------------- Vectored MEI ----------------
        csr_mstatus = 32'h0000_0008;
        csr_mie     = 32'h0000_0880;
        csr_mip     = 32'h0000_0880;
        csr_mtvec   = 32'h0000_0101;
        int_pc      = 32'h0000_0200;
        run_event("mei_vec", 0);
        check("mei_vec mcause_const", new_mcause, 32'h8000_000B);
        check("mei_vec mepc_const", new_mepc, 32'h0000_0200);

        // ---------------- Interrupt beats exception ----------------
        csr_mstatus = 32'h0000_0008;
        csr_mie     = 32'h0000_0080;
        csr_mip     = 32'h0000_0080;
        csr_mtvec   = 32'h0000_0400;
        ex_valid    = 1'b1;
        ex_cause    = 4'd11;
        ex_pc       = 32'h0000_01F0;
        int_pc      = 32'h0000_0300;
        run_event("mti_over_exc", 1);
        check("mti_over_exc mcause_const", new_mcause, 32'h8000_0007);

        // Same with MIE clear: the exception wins.
        csr_mstatus = 32'h0000_0000;
        csr_mie     = 32'h0000_0080;
        csr_mip     = 32'h0000_0080;
        csr_mtvec   = 32'h0000_0400;
        ex_valid    = 1'b1;
        ex_cause    = 4'd11;
        ex_pc       = 32'h0000_01F0;
        run_event("exc_mie0", 0);
        check("exc_mie0 mcause_const", new_mcause, 32'h0000_000B);
        check("exc_mie0 mepc_const", new_mepc, 32'h0000_01F0);

        // ---------------- mret ----------------
        csr_mstatus = 32'h0000_0000;
        mret_valid  = 1'b1;
        csr_mepc    = 32'h0000_1236;
        run_event("mret", 0);
        check("mret mcause_unchanged", new_mcause, 32'h0000_000B);

        // ---------------- Long redirect stall ----------------
        csr_mtvec = 32'h0000_2002;  // mode 10 -> direct
        ex_valid  = 1'b1;
        ex_cause  = 4'd2;
        ex_pc     = 32'h0000_3000;
        run_event("stall5", 5);

        // ---------------- Reset during COMMIT ----------------
        csr_mtvec = 32'h0000_0800;
        ex_valid  = 1'b1;
        ex_cause  = 4'd5;
        ex_pc     = 32'h0000_4444;
        tick();
        check_bit("rst_mid flush_before", flush, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        quiet();
        m_mepc   = 32'd0;
        m_mcause = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all_zero("rst_after");
        end

        // ---------------- pipe_ready gating ----------------
        csr_mstatus = 32'h0000_0008;
        csr_mie     = 32'h0000_0008;
        csr_mip     = 32'h0000_0008;
        csr_mtvec   = 32'h0000_0101;
        int_pc      = 32'h0000_0500;
        pipe_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bit("gated busy", busy, 1'b0);
            check_bit("gated flush", flush, 1'b0);
        end
        pipe_ready = 1'b1;
        run_event("msi_release", 0);
        check("msi_release mcause_const", new_mcause, 32'h8000_0003);

        // ---------------- Randomized ----------------
        for (int n = 0; n < 60; n++) begin
            csr_mstatus = $urandom;
            csr_mie     = $urandom;
            csr_mip     = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            csr_mtvec   = $urandom;
            csr_mepc    = $urandom;
            int_pc      = $urandom;
            ex_pc       = $urandom;
            ex_cause    = 4'($urandom);
            ex_valid    = 1'($urandom);
            mret_valid  = 1'($urandom);
            pipe_ready  = ($urandom_range(0, 3) != 0);
            e = predict();
            if (e.kind == 2'd0) begin
                tick();
                check_bit("rnd_none busy", busy, 1'b0);
                check_bit("rnd_none strobe", exception_occurred | exception_returned | flush, 1'b0);
                check("rnd_none mcause", new_mcause, m_mcause);
                check("rnd_none mepc", new_mepc, m_mepc);
                quiet();
            end else begin
                run_event("rnd", $urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
# trap_controller

Machine-mode trap sequencer between the pipeline and the CSR file. Arbitrates pending interrupts, synchronous exceptions and `mret`, then drives the CSR trap-update strobes. It also flushes the pipeline and issues a PC redirect to the trap vector or the saved `mepc` through a valid/ready handshake. It is the only producer of `exception_occurred`, `exception_returned`, `new_mepc`, `new_mcause` and `new_mtval`.

## Interface
- `VECTORED_EN`, default 1: when 1, `mtvec` mode 1 is honoured for interrupts. When 0, all traps use direct mode.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pipe_ready`  in  1  pipeline is at an instruction boundary and not stalled. Events are sampled only when it is 1.
- `ex_valid`  in  1  synchronous exception request from the instruction at `ex_pc`.
- `ex_cause`  in  4  exception code.
- `ex_pc`  in  32  PC of the faulting instruction.
- `mret_valid`  in  1  `mret` reached commit.
- `int_pc`  in  32  PC of the next instruction to execute. Saved as `mepc` on an interrupt.
- `csr_mstatus`, `csr_mie`, `csr_mip`, `csr_mtvec`, `csr_mepc`  in  32 each  live CSR values. Only `mstatus[3]` (MIE) is used from `csr_mstatus`, and only bits 11/7/3 from `csr_mie` and `csr_mip`.
- `exception_occurred`  out  1  one-cycle trap-entry strobe to the CSR file.
- `exception_returned`  out  1  one-cycle `mret` strobe to the CSR file.
- `new_mepc`, `new_mcause`, `new_mtval`  out  32 each  trap data. `new_mtval` is constant 0.
- `flush`  out  1  kill all in-flight instructions.
- `busy`  out  1  state ≠ IDLE. Stalls fetch and issue.
- `redirect_valid`  out  1  `redirect_pc` is valid.
- `redirect_pc`  out  32  new fetch PC.
- `redirect_ready`  in  1  fetch unit accepts the redirect.

## Operation
- FSM states: IDLE, COMMIT, REDIRECT.
- An event is captured in IDLE when `pipe_ready` = 1. Priority order:
  - interrupt, when MIE && |(mie & mip & 0x888);
  - `ex_valid`;
  - `mret_valid`.
- Interrupt sub-priority: MEI (code 11) > MSI (3) > MTI (7).
- Registers loaded at capture:
  - Interrupt: `new_mepc` = `int_pc`; `new_mcause` = {1'b1, 27'b0, code}.
  - Exception: `new_mepc` = `ex_pc`; `new_mcause` = {28'b0, `ex_cause`}.
  - `mret`: `new_mepc` and `new_mcause` are unchanged.
- Redirect target, computed at capture and registered into `redirect_pc`:
  - base = {`mtvec`[31:2], 2'b00}.
  - Vectored interrupt (VECTORED_EN = 1, `mtvec`[1:0] = 01): base + (code << 2), mod 2^32.
  - Any other trap, including `mtvec` modes 10 and 11: base.
  - `mret`: {`csr_mepc`[31:2], 2'b00}.
- IDLE → COMMIT on capture.
- COMMIT lasts exactly one cycle:
  - `flush` = 1.
  - `exception_occurred` = 1 for a trap, or `exception_returned` = 1 for `mret`. Never both.
  - Next state: REDIRECT.
- REDIRECT: `redirect_valid` = 1 with `redirect_pc` held stable until `redirect_ready` = 1. On the handshake cycle, state → IDLE.
- While not in IDLE, all event inputs are ignored. An interrupt deasserting after capture does not abort the trap.
- `busy` is decoded combinationally from state. All other outputs are registered.

## Timing
- Reset values: state IDLE. All outputs are 0: strobes, `flush`, `busy`, `redirect_valid`, `redirect_pc`, `new_mepc`, `new_mcause`, `new_mtval`.
- Reset asserted mid-sequence returns the FSM to IDLE immediately (asynchronous). No strobe fires afterwards.
- Cycle timeline, with capture at edge 0:
  - cycle 1: COMMIT, strobe + `flush`;
  - cycle 2 onward: `redirect_valid`.
- Minimum event-to-IDLE time is 3 cycles (`redirect_ready` already high).
- `new_mepc` and `new_mcause` are stable from cycle 1 until the next capture.
- The CSR file updates `mstatus`/`mepc` at the end of COMMIT. The `mret` target comes from the `csr_mepc` value sampled at capture.
- A new event can be captured in the cycle after the redirect handshake. Back-to-back traps are therefore separated by at least one IDLE cycle.
- `pipe_ready` = 0 in IDLE delays capture indefinitely. No state change occurs.

## Test plan
- MIE = 1, mie = mip = 0x880, `mtvec` = 0x0000_0101, `int_pc` = 0x200 → `new_mcause` = 0x8000_000B, `new_mepc` = 0x200, `redirect_pc` = 0x12C, `exception_occurred` pulses 1 cycle after capture.
- `ex_valid` with `ex_cause` = 11, `ex_pc` = 0x1F0, plus pending MTI with MIE = 1, `mtvec` = 0x400 → interrupt wins: `new_mcause` = 0x8000_0007, `redirect_pc` = 0x400. Repeat with MIE = 0 → `new_mcause` = 0xB, `new_mepc` = 0x1F0.
- `mret_valid` with `csr_mepc` = 0x0000_1236 → `exception_returned` 1 cycle, `exception_occurred` stays 0, `redirect_pc` = 0x1234.
- Hold `redirect_ready` = 0 for 5 cycles → `redirect_valid` and `redirect_pc` stable for all 5 cycles, `busy` = 1, and a new `ex_valid` during this window is ignored.
- Assert `rst_n` = 0 during COMMIT → all outputs 0 immediately; after release, no strobe or redirect appears.
- `pipe_ready` = 0 with MSI pending → no capture; raise `pipe_ready` → capture on the same edge, cause 0x8000_0003.
